// File: rtl/rmii_pkg.sv
// Shared RMII definitions: speed codes, dibit values, receive FSM states and
// the received-byte payload layout.
package rmii_pkg;

    localparam int unsigned DIBIT_W    = 2;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_W     = BYTE_W + 1;
    localparam int unsigned SPEED_W    = 2;
    localparam int unsigned DIV_W      = 4;
    localparam int unsigned PRE_CNT_W  = 8;
    localparam int unsigned BYTE_CNT_W = 11;

    localparam logic [SPEED_W-1:0] SPEED_CODE_100_DEFAULT = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_CODE_10_DEFAULT  = SPEED_W'(0);

    // Divider terminal counts: one clock per dibit at 100M, ten at 10M.
    localparam logic [DIV_W-1:0] DIV_LIMIT_100 = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_LIMIT_10  = DIV_W'(9);

    localparam logic [DIBIT_W-1:0] DIBIT_IDLE          = 2'b00;
    localparam logic [DIBIT_W-1:0] DIBIT_PREAMBLE      = 2'b01;
    localparam logic [DIBIT_W-1:0] DIBIT_SFD           = 2'b11;
    localparam logic [DIBIT_W-1:0] DIBIT_FALSE_CARRIER = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_type;

    // Byte handed to the MAC: first marks the first byte after SFD.
    typedef struct packed {
        logic              first;
        logic [BYTE_W-1:0] octet;
    } rx_data_t;

endpackage

// File: rtl/rmii_sample_strobe.sv
// RMII sample strobe generator, shared by receive and transmit paths.
// Ports:
//   clock, reset_n  reference clock, synchronous active-low reset
//   resync          forces the divider phase to 0 this clock and latches speed_code
//   speed_code      link speed; anything other than the 10M code runs at 100M
//   strobe_c        combinational strobe, high at mid-dibit (div == limit>>1)
module rmii_sample_strobe
    import rmii_pkg::*;
#(
    parameter logic [SPEED_W-1:0] SPEED_CODE_100_MEGABIT = SPEED_CODE_100_DEFAULT,
    parameter logic [SPEED_W-1:0] SPEED_CODE_10_MEGABIT  = SPEED_CODE_10_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               resync,
    input  logic [SPEED_W-1:0] speed_code,
    output logic               strobe_c
);

    logic [SPEED_W-1:0] speed_q;
    logic [SPEED_W-1:0] speed_eff;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic [DIV_W-1:0]   div_now;
    logic [DIV_W-1:0]   limit;

    // Divider phase and strobe; a resync takes effect in the same clock.
    always_comb begin
        speed_eff = resync ? speed_code : speed_q;
        limit     = (speed_eff == SPEED_CODE_10_MEGABIT) ? DIV_LIMIT_10 : DIV_LIMIT_100;
        div_now   = resync ? '0 : div_q;
        strobe_c  = (div_now == (limit >> 1));
        div_d     = (div_now >= limit) ? '0 : div_now + DIV_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q   <= '0;
            speed_q <= SPEED_CODE_100_MEGABIT;
        end else begin
            div_q <= div_d;
            if (resync) begin
                speed_q <= speed_code;
            end
        end
    end

endmodule

// File: rtl/rmii_byte_receiver.sv
// RMII receive deframer: strips preamble/SFD and assembles LSB-first dibits
// into bytes for the MAC.
// Ports:
//   clock, reset_n  50 MHz REF_CLK, synchronous active-low reset
//   crs_dv, rxd     RMII receive interface (already synchronous)
//   speed_code      link speed, latched at the start of each frame
//   data            {first-byte flag, byte}
//   data_valid      one-clock strobe qualifying data
//   frame_done      one-clock end-of-frame strobe
//   frame_error     qualifies frame_done: misaligned end or oversize
//   rx_active       high from SFD until frame_done
module rmii_byte_receiver
    import rmii_pkg::*;
#(
    parameter logic [SPEED_W-1:0] SPEED_CODE_100_MEGABIT = SPEED_CODE_100_DEFAULT,
    parameter logic [SPEED_W-1:0] SPEED_CODE_10_MEGABIT  = SPEED_CODE_10_DEFAULT,
    parameter int unsigned        MIN_PREAMBLE_DIBITS    = 4,
    parameter int unsigned        MAX_FRAME_BYTES        = 1522
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               crs_dv,
    input  logic [DIBIT_W-1:0] rxd,
    input  logic [SPEED_W-1:0] speed_code,
    output logic [DATA_W-1:0]  data,
    output logic               data_valid,
    output logic               frame_done,
    output logic               frame_error,
    output logic               rx_active
);

    localparam logic [PRE_CNT_W-1:0]  MIN_PRE      = PRE_CNT_W'(MIN_PREAMBLE_DIBITS);
    localparam logic [BYTE_CNT_W-1:0] OVERSIZE_CNT = BYTE_CNT_W'(MAX_FRAME_BYTES + 1);

    state_type             state_q, state_d;
    logic                  armed_q, armed_d;
    logic                  synced_q, synced_d;
    logic [PRE_CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]            dib_idx_q, dib_idx_d;
    logic [5:0]            shift_q, shift_d;
    logic                  first_q, first_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    rx_data_t              data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_error_q, frame_error_d;
    logic                  rx_active_q, rx_active_d;
    logic                  resync_c;
    logic                  strobe_c;

    // First clock of a candidate preamble re-phases the divider to the dibit edge.
    assign resync_c = (state_q == S_IDLE) && armed_q && crs_dv
                      && (rxd == DIBIT_PREAMBLE) && !synced_q;

    rmii_sample_strobe #(
        .SPEED_CODE_100_MEGABIT (SPEED_CODE_100_MEGABIT),
        .SPEED_CODE_10_MEGABIT  (SPEED_CODE_10_MEGABIT)
    ) u_strobe (
        .clock      (clock),
        .reset_n    (reset_n),
        .resync     (resync_c),
        .speed_code (speed_code),
        .strobe_c   (strobe_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q | ~crs_dv;
        synced_d      = synced_q;
        pre_cnt_d     = pre_cnt_q;
        dib_idx_d     = dib_idx_q;
        shift_d       = shift_q;
        first_d       = first_q;
        byte_cnt_d    = byte_cnt_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        rx_active_d   = rx_active_q;

        // Only one resync per idle carrier episode.
        if ((state_q != S_IDLE) || !crs_dv) begin
            synced_d = 1'b0;
        end else if (resync_c) begin
            synced_d = 1'b1;
        end

        if (strobe_c) begin
            unique case (state_q)
                S_IDLE: begin
                    if (armed_q && crs_dv && (rxd == DIBIT_PREAMBLE)) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = PRE_CNT_W'(1);
                    end
                end
                S_PREAMBLE: begin
                    if (!crs_dv) begin
                        state_d = S_IDLE;
                    end else if (rxd == DIBIT_PREAMBLE) begin
                        if (pre_cnt_q != '1) begin
                            pre_cnt_d = pre_cnt_q + PRE_CNT_W'(1);
                        end
                    end else if ((rxd == DIBIT_SFD) && (pre_cnt_q >= MIN_PRE)) begin
                        state_d     = S_DATA;
                        dib_idx_d   = 2'd0;
                        first_d     = 1'b1;
                        byte_cnt_d  = '0;
                        rx_active_d = 1'b1;
                    end else begin
                        // Early SFD, false carrier or idle dibit inside preamble.
                        state_d = S_DROP;
                    end
                end
                S_DATA: begin
                    if (byte_cnt_q >= OVERSIZE_CNT) begin
                        // Oversize byte was already emitted last strobe; abort now.
                        state_d       = S_DROP;
                        frame_done_d  = 1'b1;
                        frame_error_d = 1'b1;
                        rx_active_d   = 1'b0;
                    end else if (!crs_dv) begin
                        state_d       = S_IDLE;
                        frame_done_d  = 1'b1;
                        frame_error_d = (dib_idx_q != 2'd0);
                        rx_active_d   = 1'b0;
                    end else begin
                        dib_idx_d = dib_idx_q + 2'd1;
                        unique case (dib_idx_q)
                            2'd0: shift_d[1:0] = rxd;
                            2'd1: shift_d[3:2] = rxd;
                            2'd2: shift_d[5:4] = rxd;
                            default: begin
                                data_d.first = first_q;
                                data_d.octet = {rxd, shift_q};
                                data_valid_d = 1'b1;
                                first_d      = 1'b0;
                                if (byte_cnt_q != '1) begin
                                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    if (!crs_dv) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            armed_q       <= 1'b0;
            synced_q      <= 1'b0;
            pre_cnt_q     <= '0;
            dib_idx_q     <= '0;
            shift_q       <= '0;
            first_q       <= 1'b0;
            byte_cnt_q    <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            rx_active_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            synced_q      <= synced_d;
            pre_cnt_q     <= pre_cnt_d;
            dib_idx_q     <= dib_idx_d;
            shift_q       <= shift_d;
            first_q       <= first_d;
            byte_cnt_q    <= byte_cnt_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            rx_active_q   <= rx_active_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign rx_active   = rx_active_q;

endmodule
